// File: rtl/tx_stream_unit_if.sv
// rtl/tx_stream_unit_if.sv - host read port and show-ahead FIFO port of tx_stream_unit
interface tx_stream_unit_if #(
  parameter int DATA_W = 32
);
  logic              avs_read;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_waitrequest;
  logic [DATA_W-1:0] fifo_q;
  logic              fifo_empty;
  logic              fifo_pop;

  modport slave (
    input  avs_read, fifo_q, fifo_empty,
    output avs_readdata, avs_waitrequest, fifo_pop
  );

  modport master (
    output avs_read, fifo_q, fifo_empty,
    input  avs_readdata, avs_waitrequest, fifo_pop
  );
endinterface

// File: rtl/tx_stream_unit.sv
// rtl/tx_stream_unit.sv - streams optional line-count header plus FIFO burst to an Avalon-MM read host
module tx_stream_unit #(
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 8,
  parameter int WD_W        = 16,
  parameter int WAIT_STATES = 0,
  parameter int HDR_EN      = 1,
  parameter logic [DATA_W-1:0] WD_PATTERN = DATA_W'(32'hDEAD_0BAD)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             clear,
  input  logic             tx_en,
  input  logic [CNT_W-1:0] count_in,
  input  logic [WD_W-1:0]  wd_limit,
  tx_stream_unit_if.slave  bus,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             wd_trigger
);

  localparam logic [2:0] WS_MAX = 3'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA, S_DONE} state_t;

  state_t            state, state_nxt;
  logic              tx_en_q;
  logic [CNT_W-1:0]  len, sent;
  logic [2:0]        ws_cnt;
  logic [WD_W-1:0]   wd_cnt;
  logic              en_rise, en_fall, ready, wd_fire, waitreq;
  logic              accept, word_accept, pop;
  logic [DATA_W-1:0] rdata;

  always_comb begin
    en_rise = tx_en & ~tx_en_q;
    en_fall = ~tx_en & tx_en_q;
    case (state)
      S_HEADER: ready = 1'b1;
      S_DATA:   ready = ~bus.fifo_empty;
      default:  ready = 1'b0;
    endcase
    ready       = ready & ~clear;
    wd_fire     = ~clear & bus.avs_read & (wd_limit != '0) & (wd_cnt == wd_limit);
    waitreq     = ~(bus.avs_read & ready & (ws_cnt == WS_MAX)) & ~wd_fire;
    accept      = bus.avs_read & ~waitreq;
    // a watchdog release completes the host read but never consumes a word
    word_accept = accept & ~wd_fire;
    pop         = word_accept & (state == S_DATA);
    if (wd_fire) begin
      rdata = WD_PATTERN;
    end else begin
      case (state)
        S_HEADER: rdata = DATA_W'(len);
        S_DATA:   rdata = bus.fifo_q;
        default:  rdata = '0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    if (wd_fire) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (en_rise) begin
            if (HDR_EN != 0)          state_nxt = S_HEADER;
            else if (count_in == '0)  state_nxt = S_DONE;
            else                      state_nxt = S_DATA;
          end
        end
        S_HEADER: begin
          if (en_fall)          state_nxt = S_IDLE;
          else if (word_accept) state_nxt = (len == '0) ? S_DONE : S_DATA;
        end
        S_DATA: begin
          if (en_fall)                                        state_nxt = S_IDLE;
          else if (word_accept && ((sent + 1'b1) == len))     state_nxt = S_DONE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      tx_en_q    <= 1'b0;
      len        <= '0;
      sent       <= '0;
      ws_cnt     <= '0;
      wd_cnt     <= '0;
      wd_trigger <= 1'b0;
    end else if (clear) begin
      state      <= S_IDLE;
      tx_en_q    <= 1'b0;
      len        <= '0;
      sent       <= '0;
      ws_cnt     <= '0;
      wd_cnt     <= '0;
      wd_trigger <= 1'b0;
    end else begin
      state   <= state_nxt;
      tx_en_q <= tx_en;
      if (state == S_IDLE && en_rise && !wd_fire) begin
        len  <= count_in;
        sent <= '0;
      end else if (pop) begin
        sent <= sent + 1'b1;
      end
      // wait-state counter saturates so a read stalled by an empty FIFO goes through at once
      if (!bus.avs_read || accept) ws_cnt <= '0;
      else if (ws_cnt != WS_MAX)   ws_cnt <= ws_cnt + 1'b1;
      if (!bus.avs_read || accept) wd_cnt <= '0;
      else if (waitreq)            wd_cnt <= wd_cnt + 1'b1;
      if (wd_fire) wd_trigger <= 1'b1;
    end
  end

  assign bus.avs_readdata    = rdata;
  assign bus.avs_waitrequest = waitreq;
  assign bus.fifo_pop        = pop;
  assign tx_busy             = (state != S_IDLE);
  assign tx_done             = (state == S_DONE);

endmodule

// File: tb/tb_tx_stream_unit.sv
// tb/tb_tx_stream_unit.sv - scoreboard bench for tx_stream_unit (header+WS0 and no-header+WS2 instances)
module tb_tx_stream_unit;

  typedef struct packed {
    logic [31:0] d;
    logic        p;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, clear;
  logic        tx_en0, tx_en1;
  logic [7:0]  cnt0, cnt1;
  logic [15:0] wdl0, wdl1;
  logic        busy0, busy1, done0, done1, wdt0, wdt1;

  int checks = 0;
  int errors = 0;

  tx_stream_unit_if #(.DATA_W(32)) bus0 ();
  tx_stream_unit_if #(.DATA_W(32)) bus1 ();

  tx_stream_unit #(.HDR_EN(1), .WAIT_STATES(0)) u0 (
    .clk_in(clk), .rst(rst), .clear(clear), .tx_en(tx_en0), .count_in(cnt0),
    .wd_limit(wdl0), .bus(bus0.slave), .tx_busy(busy0), .tx_done(done0), .wd_trigger(wdt0)
  );

  tx_stream_unit #(.HDR_EN(0), .WAIT_STATES(2)) u1 (
    .clk_in(clk), .rst(rst), .clear(clear), .tx_en(tx_en1), .count_in(cnt1),
    .wd_limit(wdl1), .bus(bus1.slave), .tx_busy(busy1), .tx_done(done1), .wd_trigger(wdt1)
  );

  always #5 clk = ~clk;

  // show-ahead FIFO models: words become visible once pushed, head advances on pop
  logic [31:0] src0 [64];
  logic [31:0] src1 [64];
  int unsigned avail0 = 0, avail1 = 0, rd0 = 0, rd1 = 0;
  logic        flush0 = 1'b0, flush1 = 1'b0;

  always @(posedge clk) begin
    if (flush0) rd0 <= avail0; else if (bus0.fifo_pop) rd0 <= rd0 + 1;
    if (flush1) rd1 <= avail1; else if (bus1.fifo_pop) rd1 <= rd1 + 1;
  end

  assign bus0.fifo_empty = (rd0 >= avail0);
  assign bus0.fifo_q     = src0[rd0[5:0]];
  assign bus1.fifo_empty = (rd1 >= avail1);
  assign bus1.fifo_q     = src1[rd1[5:0]];

  // expected stream per instance: every accepted read, in order, and whether it pops
  ent_t        exp0[$];
  ent_t        exp1[$];
  int          pops [2];
  int          dones[2];
  logic [31:0] last_rd[2];

  task automatic cmp(input int k, input logic rdv, input logic wr, input logic [31:0] rdat,
                     input logic pop, input logic done);
    ent_t e;
    logic exp_pop;
    int   n;
    exp_pop = 1'b0;
    if (rdv === 1'b1 && wr === 1'b0) begin
      checks++;
      n = (k == 0) ? exp0.size() : exp1.size();
      if (n == 0) begin
        errors++;
        $display("FAIL accept%0d_unexpected readdata=%h required=no accept", k, rdat);
      end else begin
        if (k == 0) e = exp0.pop_front(); else e = exp1.pop_front();
        exp_pop = e.p;
        last_rd[k] = rdat;
        if (rdat !== e.d) begin
          errors++;
          $display("FAIL readdata%0d got=%h required=%h", k, rdat, e.d);
        end
      end
    end
    checks++;
    if (pop !== exp_pop) begin
      errors++;
      $display("FAIL fifo_pop%0d got=%b required=%b", k, pop, exp_pop);
    end
    if (pop === 1'b1) pops[k]++;
    if (done === 1'b1) dones[k]++;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cmp(0, bus0.avs_read, bus0.avs_waitrequest, bus0.avs_readdata, bus0.fifo_pop, done0);
      cmp(1, bus1.avs_read, bus1.avs_waitrequest, bus1.avs_readdata, bus1.fifo_pop, done1);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", nm, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_read(input int k, input logic v);
    if (k == 0) bus0.avs_read = v; else bus1.avs_read = v;
  endtask

  task automatic push(input int k, input logic [31:0] w);
    if (k == 0) begin src0[avail0[5:0]] = w; avail0++; end
    else        begin src1[avail1[5:0]] = w; avail1++; end
  endtask

  task automatic expect_w(input int k, input logic [31:0] d, input logic p);
    ent_t e;
    e.d = d;
    e.p = p;
    if (k == 0) exp0.push_back(e); else exp1.push_back(e);
  endtask

  task automatic flush(input int k);
    if (k == 0) flush0 = 1'b1; else flush1 = 1'b1;
    tick(1);
    flush0 = 1'b0;
    flush1 = 1'b0;
  endtask

  function automatic logic acc(input int k);
    if (k == 0) return bus0.avs_read && !bus0.avs_waitrequest;
    return bus1.avs_read && !bus1.avs_waitrequest;
  endfunction

  task automatic rd(input int k, input int max, input bit hold, output int stalls);
    bit got;
    got    = 1'b0;
    stalls = 0;
    set_read(k, 1'b1);
    while (!got && stalls <= max) begin
      @(negedge clk);
      if (acc(k)) got = 1'b1; else stalls++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL rd%0d_timeout stalls=%0d required<=%0d", k, stalls, max);
    end
    tick(1);
    if (!hold) set_read(k, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=hang required=finish");
    $fatal(1);
  end

  initial begin
    int st, p0, d0;
    rst = 1'b1; clear = 1'b0;
    tx_en0 = 1'b0; tx_en1 = 1'b0; cnt0 = '0; cnt1 = '0; wdl0 = '0; wdl1 = '0;
    bus0.avs_read = 1'b0; bus1.avs_read = 1'b0;
    pops = '{0, 0}; dones = '{0, 0}; last_rd = '{32'h0, 32'h0};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_waitreq0", {31'b0, bus0.avs_waitrequest}, 32'd1);
    chk("rst_rdata0",   bus0.avs_readdata, 32'd0);
    chk("rst_pop0",     {31'b0, bus0.fifo_pop}, 32'd0);
    chk("rst_busy0",    {31'b0, busy0}, 32'd0);
    chk("rst_done0",    {31'b0, done0}, 32'd0);
    chk("rst_wdt0",     {31'b0, wdt0}, 32'd0);
    chk("rst_waitreq1", {31'b0, bus1.avs_waitrequest}, 32'd1);
    chk("rst_busy1",    {31'b0, busy1}, 32'd0);

    // header 3 then A,B,C on four consecutive cycles
    push(0, 32'hA000_000A); push(0, 32'hB000_000B); push(0, 32'hC000_000C);
    expect_w(0, 32'd3, 1'b0);
    expect_w(0, 32'hA000_000A, 1'b1);
    expect_w(0, 32'hB000_000B, 1'b1);
    expect_w(0, 32'hC000_000C, 1'b1);
    cnt0 = 8'd3; tx_en0 = 1'b1;
    tick(1);
    chk("t1_busy", {31'b0, busy0}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      rd(0, 5, (i < 3), st);
      chk($sformatf("t1_stall%0d", i), st, 32'd0);
      if (i == 0) chk("t1_header", last_rd[0], 32'd3);
    end
    @(negedge clk);
    chk("t1_done", {31'b0, done0}, 32'd1);
    tick(1);
    chk("t1_done_pulse", {31'b0, done0}, 32'd0);
    chk("t1_idle", {31'b0, busy0}, 32'd0);
    chk("t1_pops", pops[0], 32'd3);
    chk("t1_last", last_rd[0], 32'hC000_000C);
    tx_en0 = 1'b0;
    tick(1);

    // watchdog: empty FIFO in DATA, limit 5
    d0 = dones[0];
    expect_w(0, 32'd2, 1'b0);
    expect_w(0, 32'hDEAD_0BAD, 1'b0);
    cnt0 = 8'd2; wdl0 = 16'd5; tx_en0 = 1'b1;
    tick(1);
    rd(0, 5, 1'b1, st);
    chk("t2_hdr_stall", st, 32'd0);
    rd(0, 20, 1'b0, st);
    chk("t2_wd_stalls", st, 32'd5);
    chk("t2_wd_pattern", last_rd[0], 32'hDEAD_0BAD);
    chk("t2_wdt", {31'b0, wdt0}, 32'd1);
    chk("t2_idle", {31'b0, busy0}, 32'd0);
    tx_en0 = 1'b0;
    tick(3);
    chk("t2_sticky", {31'b0, wdt0}, 32'd1);
    chk("t2_no_done", dones[0], d0);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("t2_clear_wdt", {31'b0, wdt0}, 32'd0);

    // watchdog off: 100 empty cycles, then a word arrives
    wdl0 = 16'd0; cnt0 = 8'd1;
    expect_w(0, 32'd1, 1'b0);
    expect_w(0, 32'h0123_4567, 1'b1);
    tx_en0 = 1'b1;
    tick(1);
    rd(0, 5, 1'b1, st);
    tick(99);
    chk("t3_stalled", {31'b0, bus0.avs_waitrequest}, 32'd1);
    chk("t3_no_wdt", {31'b0, wdt0}, 32'd0);
    push(0, 32'h0123_4567);
    rd(0, 3, 1'b0, st);
    chk("t3_stall_after_push", st, 32'd0);
    @(negedge clk);
    chk("t3_done", {31'b0, done0}, 32'd1);
    tx_en0 = 1'b0;
    tick(1);

    // abort by dropping tx_en after 1 of 4 data words
    d0 = dones[0]; p0 = pops[0];
    push(0, 32'hD0); push(0, 32'hD1); push(0, 32'hD2); push(0, 32'hD3);
    expect_w(0, 32'd4, 1'b0);
    expect_w(0, 32'hD0, 1'b1);
    cnt0 = 8'd4; tx_en0 = 1'b1;
    tick(1);
    rd(0, 5, 1'b1, st);
    rd(0, 5, 1'b0, st);
    tx_en0 = 1'b0;
    tick(1);
    chk("t4_abort_idle", {31'b0, busy0}, 32'd0);
    chk("t4_pops", pops[0], p0 + 1);
    set_read(0, 1'b1);
    tick(3);
    chk("t4_idle_stall", {31'b0, bus0.avs_waitrequest}, 32'd1);
    set_read(0, 1'b0);
    tick(2);
    chk("t4_no_done", dones[0], d0);
    flush(0);

    // clear mid-burst with a read pending on a ready FIFO word
    push(0, 32'hE0); push(0, 32'hE1);
    expect_w(0, 32'd2, 1'b0);
    cnt0 = 8'd2; tx_en0 = 1'b1;
    tick(1);
    rd(0, 5, 1'b0, st);
    set_read(0, 1'b1); clear = 1'b1; tx_en0 = 1'b0;
    tick(1);
    clear = 1'b0;
    chk("t5_busy", {31'b0, busy0}, 32'd0);
    chk("t5_waitreq", {31'b0, bus0.avs_waitrequest}, 32'd1);
    chk("t5_rdata", bus0.avs_readdata, 32'd0);
    chk("t5_pop", {31'b0, bus0.fifo_pop}, 32'd0);
    chk("t5_done", {31'b0, done0}, 32'd0);
    set_read(0, 1'b0);
    tick(1);
    chk("t5_stay_idle", {31'b0, busy0}, 32'd0);
    flush(0);

    // no header, two wait states, single word
    push(1, 32'h5555_AAAA);
    expect_w(1, 32'h5555_AAAA, 1'b1);
    cnt1 = 8'd1; tx_en1 = 1'b1;
    tick(1);
    rd(1, 10, 1'b0, st);
    chk("t6_ws_stalls", st, 32'd2);
    @(negedge clk);
    chk("t6_done", {31'b0, done1}, 32'd1);
    tx_en1 = 1'b0;
    tick(1);

    // no header, zero length: done pulse, no pops, reads stall
    p0 = pops[1];
    cnt1 = 8'd0; tx_en1 = 1'b1;
    tick(1);
    @(negedge clk);
    chk("t7_done", {31'b0, done1}, 32'd1);
    tick(1);
    chk("t7_done_pulse", {31'b0, done1}, 32'd0);
    chk("t7_idle", {31'b0, busy1}, 32'd0);
    set_read(1, 1'b1);
    tick(4);
    chk("t7_stall", {31'b0, bus1.avs_waitrequest}, 32'd1);
    set_read(1, 1'b0);
    tx_en1 = 1'b0;
    tick(1);
    chk("t7_no_pop", pops[1], p0);
    chk("t_all_consumed", exp0.size() + exp1.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
